// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues word-aligned fetches under a credit limit and
// buffers returned words with their PCs. Optional build macro FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module fetch_ctrl #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter int unsigned     MAX_OUTSTD = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallF,
    output logic            i_req,
    output logic [XLEN-1:0] i_addr,
    input  logic            i_gnt,
    input  logic            i_rvalid,
    input  logic [31:0]     i_rdata,
    output logic [31:0]     InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            ValidF
);

    localparam int unsigned     PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned     CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0]     NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t           mem [FIFO_DEPTH];
    logic [XLEN-1:0]  fpc;
    logic [XLEN-1:0]  rpc;
    logic [CNT_W-1:0] outstd;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    logic [CNT_W:0]   inflight;
    logic [XLEN-1:0]  tgt_al;
    logic             gnt;
    logic             rsp;
    logic             rsp_live;
    logic             head_valid;
    logic             byp;
    logic             push;
    logic             pop;
    entry_t           head;
    logic             unused_tgt_lsb;

    assign unused_tgt_lsb = ^PCTargetE[1:0];

    // Issue credit, response classification and head selection.
    always_comb begin
        tgt_al     = {PCTargetE[XLEN-1:2], 2'b00};
        inflight   = (CNT_W+1)'(outstd) + (CNT_W+1)'(count);
        i_req      = rst_n && !PCSrcE
                     && (outstd < CNT_W'(MAX_OUTSTD))
                     && (inflight < (CNT_W+1)'(FIFO_DEPTH));
        i_addr     = fpc;
        gnt        = i_req && i_gnt;
        rsp        = i_rvalid && (outstd != '0);
        rsp_live   = rsp && (drop == '0) && !PCSrcE;
        head_valid = (count != '0);
`ifdef FETCH_BYPASS_EN
        byp        = rsp_live && !head_valid;
`else
        byp        = 1'b0;
`endif
        pop        = head_valid && !StallF && !PCSrcE;
        // A bypassed word that decode takes right away never enters the buffer.
        push       = rsp_live && !(byp && !StallF);
        head       = byp ? {rpc, i_rdata} : mem[rptr];
        ValidF     = head_valid || byp;
        InstrF     = ValidF ? head.instr : NOP;
        PCF        = ValidF ? head.pc : '0;
        PCPlus4F   = PCF + PC_STEP;
    end

    // Fetch/response PCs, in-flight accounting and buffer pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= RESET_PC_AL;
            rpc    <= RESET_PC_AL;
            outstd <= '0;
            drop   <= '0;
            count  <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else if (PCSrcE) begin
            // Everything still in flight, less a response landing now, is stale.
            fpc    <= tgt_al;
            rpc    <= tgt_al;
            outstd <= outstd - CNT_W'(rsp);
            drop   <= outstd - CNT_W'(rsp);
            count  <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else begin
            if (gnt) begin
                fpc <= fpc + PC_STEP;
            end
            if (rsp_live) begin
                rpc <= rpc + PC_STEP;
            end
            outstd <= outstd + CNT_W'(gnt) - CNT_W'(rsp);
            if (rsp && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Buffer storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {rpc, i_rdata};
        end
    end

    // A response with nothing in flight is a bus protocol violation.
    a_rvalid_without_req : assert property (
        @(posedge clk) disable iff (!rst_n) !(i_rvalid && (outstd == '0))
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl: a bus model answers grants in order and a
// scoreboard of expected fetch PCs is checked against every word decode consumes.
module tb_fetch_ctrl;

    localparam int unsigned XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          OP_RUN     = 0;
    localparam int          OP_RESET   = 1;
    localparam int          OP_DRAINED = 2;
`ifdef FETCH_BYPASS_EN
    localparam int          EXP_LAT    = 1;
`else
    localparam int          EXP_LAT    = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidF;

    fetch_ctrl #(
        .XLEN       (XLEN),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2),
        .MAX_OUTSTD (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .PCPlus4F  (PCPlus4F),
        .ValidF    (ValidF)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        bit          stall;
        bit          gnt;
        bit          redir;
        bit          redir_rv;
        bit          lat_chk;
        bit          hold;
        bit          chk_addr;
        logic [31:0] tgt;
        int          lat;
        int          exp_req;
        int          exp_valid;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_t;

    vec_t        vecs[$];
    bus_t        rsp_q[$];
    logic [31:0] sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_fetch;
    bit          have_ref;
    logic [31:0] ref_pc;
    bit          rv_done = 1'b0;
    bit          lat_armed;
    int          grant_cyc;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_run(input int n, input bit stall, input bit gnt, input int lat,
                           input int exp_req, input int exp_valid, input bit hold, input bit chk_addr);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = '{op: OP_RUN, stall: stall, gnt: gnt, redir: 1'b0, redir_rv: 1'b0, lat_chk: 1'b0,
                  hold: hold, chk_addr: chk_addr, tgt: 32'h0, lat: lat,
                  exp_req: exp_req, exp_valid: exp_valid};
            vecs.push_back(v);
        end
    endtask

    task automatic add_redir(input logic [31:0] tgt, input bit stall, input bit on_rv, input bit lat_chk);
        vec_t v;
        v = '{op: OP_RUN, stall: stall, gnt: 1'b1, redir: !on_rv, redir_rv: on_rv, lat_chk: lat_chk,
              hold: 1'b0, chk_addr: 1'b0, tgt: tgt, lat: 1, exp_req: -1, exp_valid: -1};
        vecs.push_back(v);
    endtask

    task automatic add_op(input int op);
        vec_t v;
        v = '{op: op, stall: 1'b0, gnt: 1'b0, redir: 1'b0, redir_rv: 1'b0, lat_chk: 1'b0,
              hold: 1'b0, chk_addr: 1'b0, tgt: 32'h0, lat: 1, exp_req: -1, exp_valid: -1};
        vecs.push_back(v);
    endtask

    // Asynchronous reset, usable at time zero or in the middle of traffic.
    task automatic do_reset();
        rst_n     = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        StallF    = 1'b0;
        i_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = 32'h0;
        #1;
        check("rst_i_req",    32'(i_req),  32'h0);
        check("rst_validf",   32'(ValidF), 32'h0);
        check("rst_instrf",   InstrF,      32'h0000_0013);
        check("rst_pcf",      PCF,         32'h0);
        check("rst_pcplus4f", PCPlus4F,    32'h4);
        rsp_q.delete();
        sb_q.delete();
        exp_fetch = RESET_PC;
        have_ref  = 1'b0;
        lat_armed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc += 2;
    endtask

    // One clock of stimulus; entered and left 1 time unit after the rising edge.
    task automatic run_row(input vec_t v);
        bit          redir;
        logic [31:0] e;
        i_rvalid = 1'b0;
        i_rdata  = 32'h0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            i_rvalid = 1'b1;
            i_rdata  = memw(rsp_q[0].addr);
            void'(rsp_q.pop_front());
        end
        redir = v.redir || (v.redir_rv && i_rvalid && !rv_done);
        if (v.redir_rv && redir) rv_done = 1'b1;
        PCSrcE    = redir;
        PCTargetE = v.tgt;
        StallF    = v.stall;
        i_gnt     = v.gnt;
        #1;
        if (v.exp_req >= 0)   check("i_req", 32'(i_req), 32'(v.exp_req));
        if (redir)            check("i_req_on_redirect", 32'(i_req), 32'h0);
        if (v.exp_valid >= 0) check("validf", 32'(ValidF), 32'(v.exp_valid));
        if (v.chk_addr)       check("i_addr_stable", i_addr, exp_fetch);
        if (!ValidF) begin
            check("nop_when_invalid", InstrF, 32'h0000_0013);
            check("pcf_zero_when_invalid", PCF, 32'h0);
        end
        if (v.hold) begin
            if (ValidF) begin
                if (!have_ref) begin
                    have_ref = 1'b1;
                    ref_pc   = PCF;
                end else begin
                    check("stall_head_pc", PCF, ref_pc);
                end
            end
        end else begin
            have_ref = 1'b0;
        end
        if (i_req && i_gnt) begin
            check("grant_addr", i_addr, exp_fetch);
            rsp_q.push_back('{addr: i_addr, due: cyc + v.lat});
            sb_q.push_back(exp_fetch);
            exp_fetch += 32'd4;
            if (lat_armed && grant_cyc < 0) grant_cyc = cyc;
        end
        if (ValidF && !StallF && !PCSrcE) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got PCF %h, expected no valid word (cycle %0d)", PCF, cyc);
            end else begin
                e = sb_q.pop_front();
                check("pop_pcf",      PCF,      e);
                check("pop_instrf",   InstrF,   memw(e));
                check("pop_pcplus4f", PCPlus4F, e + 32'd4);
            end
            if (lat_armed && grant_cyc >= 0) begin
                check("grant_to_validf_latency", 32'(cyc - grant_cyc), 32'(EXP_LAT));
                lat_armed = 1'b0;
            end
        end
        if (redir) begin
            sb_q.delete();
            exp_fetch = {v.tgt[31:2], 2'b00};
            if (v.lat_chk) begin
                lat_armed = 1'b1;
                grant_cyc = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        // op/rows: n, stall, gnt, lat, exp_req, exp_valid, hold, chk_addr
        add_op(OP_RESET);
        add_run(5, 1'b0, 1'b0, 1, 1, 0, 1'b0, 1'b1);       // grant withheld
        add_run(12, 1'b0, 1'b1, 1, -1, -1, 1'b0, 1'b0);    // streaming
        add_run(2, 1'b1, 1'b1, 1, -1, -1, 1'b1, 1'b0);     // stall, filling
        add_run(2, 1'b1, 1'b1, 1, 0, 1, 1'b1, 1'b0);       // stall, credits exhausted
        add_run(8, 1'b0, 1'b1, 1, -1, -1, 1'b0, 1'b0);     // resume
        add_run(4, 1'b0, 1'b0, 1, -1, -1, 1'b0, 1'b0);
        add_op(OP_DRAINED);
        add_run(2, 1'b0, 1'b1, 5, -1, -1, 1'b0, 1'b0);     // two slow requests in flight
        add_redir(32'h0000_0100, 1'b0, 1'b0, 1'b0);
        add_run(12, 1'b0, 1'b1, 1, -1, -1, 1'b0, 1'b0);
        add_run(4, 1'b0, 1'b0, 1, -1, -1, 1'b0, 1'b0);
        add_op(OP_DRAINED);
        add_run(4, 1'b0, 1'b1, 1, -1, -1, 1'b0, 1'b0);
        add_redir(32'h0000_0103, 1'b1, 1'b1, 1'b0);        // fires on a live response, while stalled
        add_redir(32'h0000_0103, 1'b1, 1'b1, 1'b0);
        add_redir(32'h0000_0103, 1'b1, 1'b1, 1'b0);
        add_run(10, 1'b0, 1'b1, 1, -1, -1, 1'b0, 1'b0);
        add_run(4, 1'b0, 1'b0, 1, -1, -1, 1'b0, 1'b0);
        add_op(OP_DRAINED);
        add_redir(32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1);        // wrap, redirect under stall
        add_run(10, 1'b0, 1'b1, 1, -1, -1, 1'b0, 1'b0);
        add_run(4, 1'b0, 1'b0, 1, -1, -1, 1'b0, 1'b0);
        add_op(OP_DRAINED);
        add_run(3, 1'b0, 1'b1, 1, -1, -1, 1'b0, 1'b0);
        add_op(OP_RESET);                                  // mid-traffic reset
        add_run(1, 1'b0, 1'b1, 1, 1, -1, 1'b0, 1'b1);
        add_run(8, 1'b0, 1'b1, 1, -1, -1, 1'b0, 1'b0);
        add_run(4, 1'b0, 1'b0, 1, -1, -1, 1'b0, 1'b0);
        add_op(OP_DRAINED);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_RESET: do_reset();
                OP_DRAINED: begin
                    check("all_fetched_words_delivered", 32'(sb_q.size()), 32'h0);
                    check("drained_validf", 32'(ValidF), 32'h0);
                end
                default: run_row(vecs[i]);
            endcase
        end
        check("coincident_redirect_seen", 32'(rv_done), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
